cook_sequencer: RTL and testbench
=================================

# cook_sequencer

Multi-stage cooking program sequencer between the keypad/time-entry front end and the minutes/seconds timer and magnetron control. Holds up to MAX_STAGES cooking stages (BCD time plus power level), loads each stage into the timer in turn, enables counting, and advances when the timer reaches zero. It duty-cycles the magnetron request over a 10-second window according to each stage's power level, and handles pause, resume and abort on stop or door opening.

## Interface
- MAX_STAGES, 4: number of stage slots (index width 2 bits)
- TIME_W, 12: BCD stage time {mins[11:8], sec_tens[7:4], sec_ones[3:0]}
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-clk-wide pulse per second, already synchronous to clk
- prog_wr  in  1  write prog_time/prog_power into slot prog_idx
- prog_idx  in  2  slot being written
- prog_time  in  TIME_W  BCD stage time
- prog_power  in  4  power level 0..10; values above 10 are stored as 10
- prog_len  in  3  stages to run, 1..MAX_STAGES; sampled on accepted start
- start  in  1  start/resume pulse
- stop  in  1  pause/abort pulse
- door_closed  in  1  1 = door closed
- timer_zero  in  1  timer count equals 0:00
- timer_load  out  1  one-cycle pulse; timer loads timer_time
- timer_time  out  TIME_W  time of the current stage
- timer_en  out  1  timer counts down while high
- mag_req  out  1  magnetron request to magnetron control
- stage  out  2  index of the current stage
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the program completes

## Operation
- States: IDLE, LOAD, RUN, PAUSE, NEXT, DONE.
- Slot registers: time[i] and power[i].
  - prog_wr is accepted only in IDLE and is ignored while busy.
  - Reset values: time = 0, power = 10.
- IDLE
  - start && door_closed && prog_len in 1..MAX_STAGES: latch len, set stage = 0, go to LOAD.
  - Otherwise remain in IDLE; prog_len of 0 or above MAX_STAGES ignores start.
- LOAD (one cycle)
  - If time[stage] == 0: go to NEXT, with no timer_load.
  - Otherwise: timer_load = 1, duty_cnt = 0, go to RUN.
- RUN
  - timer_en = 1 and mag_req = (duty_cnt < power[stage]).
  - On tick_1hz: duty_cnt increments modulo 10 (9 wraps to 0).
  - Priority, highest first:
    1. !door_closed goes to PAUSE.
    2. stop goes to PAUSE.
    3. timer_zero goes to NEXT.
- PAUSE
  - timer_en = 0 and mag_req = 0; duty_cnt is held and ticks are ignored.
  - stop goes to IDLE (abort): stage = 0, no done pulse.
  - Otherwise, start && door_closed goes to RUN with duty_cnt retained.
  - start with the door open is ignored.
- NEXT
  - If stage+1 == len: go to DONE.
  - Otherwise: stage = stage+1 and go to LOAD.
- DONE: done = 1 for one cycle, stage = 0, go to IDLE.
- Power 0 is a standing time: the timer counts and mag_req stays 0. Power 10 gives continuous mag_req.
- timer_time = time[stage] combinationally in every state.

## Timing
- Reset values: state = IDLE, stage = 0, duty_cnt = 0, len = 0; timer_load, timer_en, mag_req, busy and done all 0.
- Reset has priority over everything, including mid-RUN, and forces IDLE within one edge.
- Start to first timer_en: accepted start at edge N gives LOAD in cycle N+1 (timer_load high) and RUN in cycle N+2.
- The timer samples timer_load at the same edge that enters RUN, so timer_zero in the first RUN cycle already reflects the loaded value.
- Stage turnaround: timer_zero in RUN leads to NEXT for one cycle, then LOAD, then RUN. timer_en is low for 2 cycles between stages.
- Door opening in RUN: mag_req and timer_en drop on the next edge, within 1 clk.
- stop and timer_zero in the same cycle: PAUSE wins. On resume, timer_zero is still high, so the block goes straight to NEXT.
- tick_1hz in the same cycle as the RUN exit still updates duty_cnt.
- tick_1hz outside RUN has no effect.
- Program writes during busy never alter the running program.

## Test plan
- Single stage, time 0:05, power 10, start: timer_load pulses at cycle N+1, timer_en high from N+2; mag_req stays 1 for all 5 ticks; after timer_zero comes NEXT, DONE and a done pulse, with busy dropping 3 cycles after timer_zero.
- Power 3, time 0:20: mag_req is high for ticks 0–2 and low for 3–9 of each 10-tick window, giving 6 high seconds out of 20.
- Three stages (0:03 at p10, 0:00 at p5, 0:02 at p0): stage reads 0 then 2; stage 1 gets no timer_load; during stage 2 mag_req stays 0 and timer_en stays 1; done fires once.
- Door opens mid-RUN at duty_cnt = 4: timer_en and mag_req are 0 within 1 clk. Start with the door still open is ignored. After closing, start resumes RUN with duty_cnt = 4, so the next tick gives 5.
- stop in RUN, then stop in PAUSE: the block returns to IDLE with stage = 0 and no done. Assert rst mid-RUN with power 10: all outputs are 0 after one edge.
- prog_wr during RUN to the active slot: timer_time is unchanged. prog_len = 0 with start: the block stays in IDLE.

Source files
------------

// File: rtl/cook_sequencer_if.sv
// Keypad/timer-side signal bundle for the cooking program sequencer.
// master = front end / timer side, slave = sequencer.
interface cook_sequencer_if #(
  parameter int TIME_W = 12,
  parameter int IDX_W  = 2,
  parameter int LEN_W  = 3
);
  logic              tick_1hz;
  logic              prog_wr;
  logic [IDX_W-1:0]  prog_idx;
  logic [TIME_W-1:0] prog_time;
  logic [3:0]        prog_power;
  logic [LEN_W-1:0]  prog_len;
  logic              start;
  logic              stop;
  logic              door_closed;
  logic              timer_zero;
  logic              timer_load;
  logic [TIME_W-1:0] timer_time;
  logic              timer_en;
  logic              mag_req;
  logic [IDX_W-1:0]  stage;
  logic              busy;
  logic              done;

  modport master (
    output tick_1hz, prog_wr, prog_idx, prog_time, prog_power, prog_len,
           start, stop, door_closed, timer_zero,
    input  timer_load, timer_time, timer_en, mag_req, stage, busy, done
  );

  modport slave (
    input  tick_1hz, prog_wr, prog_idx, prog_time, prog_power, prog_len,
           start, stop, door_closed, timer_zero,
    output timer_load, timer_time, timer_en, mag_req, stage, busy, done
  );
endinterface

// File: rtl/cook_sequencer.sv
// Multi-stage cooking sequencer: steps through programmed stages, drives the
// timer load/enable and duty-cycles the magnetron over a 10 s window.
module cook_sequencer #(
  parameter int MAX_STAGES = 4,
  parameter int TIME_W     = 12
) (
  input logic          clk,
  input logic          rst,
  cook_sequencer_if.slave bus
);
  localparam int IDX_W = (MAX_STAGES > 1) ? $clog2(MAX_STAGES) : 1;
  localparam int LEN_W = $clog2(MAX_STAGES + 1);
  localparam logic [3:0] POWER_MAX = 4'd10;
  localparam logic [3:0] DUTY_LAST = 4'd9;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, NEXT, DONE} state_t;

  state_t            state;
  logic [TIME_W-1:0] slot_time  [MAX_STAGES];
  logic [3:0]        slot_power [MAX_STAGES];
  logic [IDX_W-1:0]  stage;
  logic [LEN_W-1:0]  len;
  logic [3:0]        duty_cnt;

  logic [3:0]        power_cur;
  logic [3:0]        duty_step;
  logic [3:0]        duty_run;
  logic [IDX_W-1:0]  stage_inc;
  logic              last_stage;
  logic              len_ok;
  logic              first_time_nz;
  logic              next_time_nz;

  assign power_cur  = slot_power[stage];
  assign duty_step  = (duty_cnt == DUTY_LAST) ? '0 : duty_cnt + 4'd1;
  assign duty_run   = bus.tick_1hz ? duty_step : duty_cnt;
  assign stage_inc  = stage + IDX_W'(1);
  assign last_stage = (LEN_W'(stage) + LEN_W'(1)) == len;
  assign len_ok     = (bus.prog_len != '0) && (bus.prog_len <= LEN_W'(MAX_STAGES));

  // A slot-0 write on the same edge as start must still decide the first load.
  assign first_time_nz = (bus.prog_wr && (bus.prog_idx == '0)) ? (bus.prog_time != '0)
                                                               : (slot_time[0] != '0);
  assign next_time_nz  = slot_time[stage_inc] != '0;

  assign bus.timer_time = slot_time[stage];
  assign bus.stage      = stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_STAGES; i++) begin
        slot_time[IDX_W'(i)]  <= '0;
        slot_power[IDX_W'(i)] <= POWER_MAX;
      end
    end else if (bus.prog_wr && (state == IDLE)) begin
      slot_time[bus.prog_idx]  <= bus.prog_time;
      slot_power[bus.prog_idx] <= (bus.prog_power > POWER_MAX) ? POWER_MAX : bus.prog_power;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      stage          <= '0;
      len            <= '0;
      duty_cnt       <= '0;
      bus.timer_load <= 1'b0;
      bus.timer_en   <= 1'b0;
      bus.mag_req    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.timer_load <= 1'b0;
      bus.done       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.door_closed && len_ok) begin
            len            <= bus.prog_len;
            stage          <= '0;
            state          <= LOAD;
            bus.busy       <= 1'b1;
            bus.timer_load <= first_time_nz;
          end
        end
        LOAD: begin
          if (slot_time[stage] == '0) begin
            state <= NEXT;
          end else begin
            state        <= RUN;
            duty_cnt     <= '0;
            bus.timer_en <= 1'b1;
            bus.mag_req  <= (power_cur != '0);
          end
        end
        RUN: begin
          // Outputs are registered, so mag_req tracks the post-tick duty count.
          if (bus.tick_1hz) duty_cnt <= duty_step;
          if (!bus.door_closed || bus.stop) begin
            state        <= PAUSE;
            bus.timer_en <= 1'b0;
            bus.mag_req  <= 1'b0;
          end else if (bus.timer_zero) begin
            state        <= NEXT;
            bus.timer_en <= 1'b0;
            bus.mag_req  <= 1'b0;
          end else begin
            bus.mag_req <= (duty_run < power_cur);
          end
        end
        PAUSE: begin
          if (bus.stop) begin
            state    <= IDLE;
            stage    <= '0;
            bus.busy <= 1'b0;
          end else if (bus.start && bus.door_closed) begin
            state        <= RUN;
            bus.timer_en <= 1'b1;
            bus.mag_req  <= (duty_cnt < power_cur);
          end
        end
        NEXT: begin
          if (last_stage) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            stage          <= stage_inc;
            state          <= LOAD;
            bus.timer_load <= next_time_nz;
          end
        end
        DONE: begin
          state    <= IDLE;
          stage    <= '0;
          bus.busy <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          stage        <= '0;
          bus.timer_en <= 1'b0;
          bus.mag_req  <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer with a behavioural minutes/seconds timer
// and a queue of expected values consumed as the DUT responds.
module tb_cook_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cook_sequencer_if #(.TIME_W(12), .IDX_W(2), .LEN_W(3)) bus ();

  cook_sequencer #(.MAX_STAGES(4), .TIME_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Timer: loads on timer_load, counts seconds down while enabled.
  logic [9:0] tmr_cnt;

  function automatic logic [9:0] bcd_secs(input logic [11:0] t);
    return 10'(t[11:8]) * 10'd60 + 10'(t[7:4]) * 10'd10 + 10'(t[3:0]);
  endfunction

  always @(posedge clk) begin
    if (rst) tmr_cnt <= '0;
    else if (bus.timer_load) tmr_cnt <= bcd_secs(bus.timer_time);
    else if (bus.timer_en && bus.tick_1hz && (tmr_cnt != '0)) tmr_cnt <= tmr_cnt - 10'd1;
  end

  assign bus.timer_zero = (tmr_cnt == '0);

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_val(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [15:0] act);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow: got %0h required <none>", act);
    end else begin
      e = sb.pop_front();
      assert (act === e.val)
      else begin
        n_fail++;
        $error("FAIL %s: got %0h required %0h", e.tag, act, e.val);
      end
    end
  endtask

  // Packed observation: {timer_load, timer_en, mag_req, busy, done, stage}.
  function automatic logic [15:0] outs();
    return {9'd0, bus.timer_load, bus.timer_en, bus.mag_req, bus.busy, bus.done, bus.stage};
  endfunction

  task automatic check_outs(input string tag, input logic [4:0] flags, input logic [1:0] st);
    expect_val(tag, {9'd0, flags, st});
    compare(outs());
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.tick_1hz = 1'b1;
    cyc();
    bus.tick_1hz = 1'b0;
  endtask

  task automatic prog(input logic [1:0] idx, input logic [11:0] t, input logic [3:0] p);
    bus.prog_wr    = 1'b1;
    bus.prog_idx   = idx;
    bus.prog_time  = t;
    bus.prog_power = p;
    cyc();
    bus.prog_wr = 1'b0;
  endtask

  task automatic start_prog(input logic [2:0] n);
    bus.prog_len = n;
    bus.start    = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic run_ticks(input int n, input logic mg, input logic [1:0] st, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check_outs(tag, {1'b0, 1'b1, mg, 1'b1, 1'b0}, st);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (bus.busy && (k < 50)) begin
      cyc();
      k++;
    end
    expect_val(tag, 16'd0);
    compare(16'(bus.busy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    rst             = 1'b1;
    bus.tick_1hz    = 1'b0;
    bus.prog_wr     = 1'b0;
    bus.prog_idx    = '0;
    bus.prog_time   = '0;
    bus.prog_power  = '0;
    bus.prog_len    = '0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.door_closed = 1'b1;
    cyc();
    cyc();
    check_outs("reset_outs", 5'b00000, 2'd0);
    expect_val("reset_time", 16'd0);
    compare(16'(bus.timer_time));
    rst = 1'b0;
    cyc();

    // Single stage 0:05 at power 10.
    prog(2'd0, 12'h005, 4'd10);
    start_prog(3'd1);
    check_outs("t1_load", 5'b10010, 2'd0);
    cyc();
    check_outs("t1_run", 5'b01110, 2'd0);
    run_ticks(5, 1'b1, 2'd0, "t1_tick");
    cyc();
    check_outs("t1_next", 5'b00010, 2'd0);
    cyc();
    check_outs("t1_done", 5'b00011, 2'd0);
    cyc();
    check_outs("t1_idle", 5'b00000, 2'd0);

    // Power 3 over 20 s: high for the first 3 s of each 10 s window.
    prog(2'd0, 12'h020, 4'd3);
    start_prog(3'd1);
    cyc();
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      expect_val("t2_mag", 16'((k % 10) < 3));
      compare(16'(bus.mag_req));
      hi += int'(bus.mag_req);
      tick();
    end
    expect_val("t2_high_secs", 16'd6);
    compare(16'(hi));
    wait_idle("t2_idle");

    // Three stages, the middle one zero-length, the last a standing time.
    prog(2'd0, 12'h003, 4'd10);
    prog(2'd1, 12'h000, 4'd5);
    prog(2'd2, 12'h002, 4'd0);
    start_prog(3'd3);
    check_outs("t3_load0", 5'b10010, 2'd0);
    cyc();
    check_outs("t3_run0", 5'b01110, 2'd0);
    run_ticks(3, 1'b1, 2'd0, "t3_tick0");
    cyc();
    check_outs("t3_next0", 5'b00010, 2'd0);
    cyc();
    check_outs("t3_load1", 5'b00010, 2'd1);
    cyc();
    check_outs("t3_next1", 5'b00010, 2'd1);
    cyc();
    check_outs("t3_load2", 5'b10010, 2'd2);
    cyc();
    check_outs("t3_run2", 5'b01010, 2'd2);
    run_ticks(2, 1'b0, 2'd2, "t3_tick2");
    cyc();
    check_outs("t3_next2", 5'b00010, 2'd2);
    cyc();
    check_outs("t3_done", 5'b00011, 2'd2);
    cyc();
    check_outs("t3_idle", 5'b00000, 2'd0);
    cyc();
    check_outs("t3_done_once", 5'b00000, 2'd0);

    // Door opens at duty_cnt 4, resume keeps the duty position.
    prog(2'd0, 12'h020, 4'd5);
    start_prog(3'd1);
    cyc();
    run_ticks(4, 1'b1, 2'd0, "t4_tick");
    bus.door_closed = 1'b0;
    cyc();
    check_outs("t4_door_pause", 5'b00010, 2'd0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check_outs("t4_start_door_open", 5'b00010, 2'd0);
    tick();
    check_outs("t4_tick_in_pause", 5'b00010, 2'd0);
    bus.door_closed = 1'b1;
    cyc();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check_outs("t4_resume", 5'b01110, 2'd0);
    run_ticks(1, 1'b0, 2'd0, "t4_duty5");
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    check_outs("t4_stop_pause", 5'b00010, 2'd0);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    check_outs("t4_abort", 5'b00000, 2'd0);
    cyc();
    check_outs("t4_no_done", 5'b00000, 2'd0);

    // stop coinciding with timer_zero: PAUSE wins, resume goes to NEXT.
    prog(2'd0, 12'h002, 4'd10);
    start_prog(3'd1);
    cyc();
    run_ticks(2, 1'b1, 2'd0, "t5_tick");
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    check_outs("t5_pause_wins", 5'b00010, 2'd0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check_outs("t5_resume", 5'b01110, 2'd0);
    cyc();
    check_outs("t5_next", 5'b00010, 2'd0);
    cyc();
    check_outs("t5_done", 5'b00011, 2'd0);
    wait_idle("t5_idle");

    // Writes while busy are dropped; reset mid-RUN clears everything.
    prog(2'd0, 12'h005, 4'd10);
    start_prog(3'd1);
    cyc();
    prog(2'd0, 12'h009, 4'd2);
    expect_val("t6_time_kept", 16'h005);
    compare(16'(bus.timer_time));
    check_outs("t6_still_run", 5'b01110, 2'd0);
    rst = 1'b1;
    cyc();
    check_outs("t6_rst_outs", 5'b00000, 2'd0);
    expect_val("t6_rst_time", 16'd0);
    compare(16'(bus.timer_time));
    rst = 1'b0;
    cyc();

    // Start ignored for bad lengths or an open door.
    prog(2'd0, 12'h005, 4'd10);
    start_prog(3'd0);
    cyc();
    check_outs("t7_len0", 5'b00000, 2'd0);
    start_prog(3'd5);
    cyc();
    check_outs("t7_len5", 5'b00000, 2'd0);
    bus.door_closed = 1'b0;
    start_prog(3'd1);
    cyc();
    check_outs("t7_door_open", 5'b00000, 2'd0);
    bus.door_closed = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
